// File: rtl/i2s_capture_rpi_out.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_capture_rpi_out
//  Description : Captures stereo I2S frames from an ADC into a small FIFO and
//                serialises them MSB first to the Raspberry Pi read link.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_capture_rpi_out #(
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i2s_bclk,
    input  logic                          i2s_lrclk,
    input  logic                          i2s_sdata,
    input  logic                          rpi_clk,
    input  logic                          rpi_enable,
    output logic                          rpi_serial,
    output logic                          rpi_interrupt,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fill
);

    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_FILL_W = c_ADDR_W + 1;
    localparam int c_CNT_W  = $clog2(WIDTH + 2);
    localparam int c_FRAME_W = 2 * WIDTH;
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(WIDTH);
    localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(FIFO_DEPTH);

    // bit positions inside the synchroniser vectors
    localparam int c_B  = 0;
    localparam int c_L  = 1;
    localparam int c_D  = 2;
    localparam int c_RC = 3;
    localparam int c_EN = 4;

    logic [4:0]                r_sync1;
    logic [4:0]                r_sync2;
    logic [4:0]                r_sync3;
    logic                      r_bclk_rise;
    logic                      r_rclk_fall;
    logic                      r_en_rise;
    logic                      r_en_fall;

    logic [c_CNT_W-1:0]        r_cnt;
    logic                      r_lr_prev;
    logic [WIDTH-1:0]          r_shift;
    logic [WIDTH-1:0]          r_left_hold;
    logic                      r_left_valid;

    logic [c_FRAME_W-1:0]      r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0]       r_wr_ptr;
    logic [c_ADDR_W-1:0]       r_rd_ptr;
    logic [c_FILL_W-1:0]       r_fill;
    logic                      r_irq;
    logic                      r_overflow;
    logic [c_FRAME_W-1:0]      r_out;

    logic                      w_lr;
    logic                      w_sd;
    logic [WIDTH-1:0]          w_word;
    logic                      w_in_slot;
    logic                      w_push;
    logic [c_FRAME_W-1:0]      w_push_data;
    logic                      w_full;
    logic                      w_pop;
    logic                      w_wr;
    logic                      w_drop;
    logic [c_FILL_W-1:0]       w_fill_next;

    // Three stages: two for metastability, the third feeds the edge detectors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_sync3     <= '0;
            r_bclk_rise <= 1'b0;
            r_rclk_fall <= 1'b0;
            r_en_rise   <= 1'b0;
            r_en_fall   <= 1'b0;
        end else begin
            r_sync1     <= {rpi_enable, rpi_clk, i2s_sdata, i2s_lrclk, i2s_bclk};
            r_sync2     <= r_sync1;
            r_sync3     <= r_sync2;
            r_bclk_rise <= r_sync2[c_B] & ~r_sync3[c_B];
            r_rclk_fall <= ~r_sync2[c_RC] & r_sync3[c_RC];
            r_en_rise   <= r_sync2[c_EN] & ~r_sync3[c_EN];
            r_en_fall   <= ~r_sync2[c_EN] & r_sync3[c_EN];
        end
    end

    // During a strobe cycle the third stage holds lrclk/sdata from the same snapshot as the bclk edge.
    assign w_lr        = r_sync3[c_L];
    assign w_sd        = r_sync3[c_D];
    assign w_word      = {r_shift[WIDTH-2:0], w_sd};
    assign w_in_slot   = (r_cnt >= c_CNT_ONE) && (r_cnt <= c_CNT_LAST);
    assign w_push      = r_bclk_rise && (w_lr == r_lr_prev) && w_lr &&
                         (r_cnt == c_CNT_LAST) && r_left_valid;
    assign w_push_data = {r_left_hold, w_word};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_lr_prev    <= 1'b1;
            r_shift      <= '0;
            r_left_hold  <= '0;
            r_left_valid <= 1'b0;
        end else if (r_bclk_rise) begin
            if (w_lr != r_lr_prev) begin
                r_cnt     <= c_CNT_ONE;
                r_lr_prev <= w_lr;
                if (!r_lr_prev && (r_cnt <= c_CNT_LAST)) begin
                    r_left_valid <= 1'b0;
                end
            end else if (w_in_slot) begin
                r_shift <= w_word;
                r_cnt   <= r_cnt + c_CNT_ONE;
                if (r_cnt == c_CNT_LAST) begin
                    if (!w_lr) begin
                        r_left_hold  <= w_word;
                        r_left_valid <= 1'b1;
                    end else begin
                        r_left_valid <= 1'b0;
                    end
                end
            end
        end
    end

    assign w_full = (r_fill == c_FILL_MAX);
    assign w_pop  = r_en_rise && (r_fill != '0);
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    always_comb begin
        w_fill_next = r_fill;
        unique case ({w_wr, w_pop})
            2'b10:   w_fill_next = r_fill + c_FILL_W'(1);
            2'b01:   w_fill_next = r_fill - c_FILL_W'(1);
            default: w_fill_next = r_fill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_irq      <= 1'b0;
            r_overflow <= 1'b0;
            r_out      <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            r_fill <= w_fill_next;
            r_irq  <= (w_fill_next != '0);

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (r_en_rise) begin
                r_overflow <= 1'b0;
            end

            // An abandoned frame is flushed so the line idles at zero.
            if (r_en_rise) begin
                r_out <= w_pop ? r_mem[r_rd_ptr] : '0;
            end else if (r_en_fall) begin
                r_out <= '0;
            end else if (r_rclk_fall && r_sync2[c_EN]) begin
                r_out <= {r_out[c_FRAME_W-2:0], 1'b0};
            end
        end
    end

    assign rpi_serial    = r_out[c_FRAME_W-1] & r_sync2[c_EN];
    assign rpi_interrupt = r_irq;
    assign overflow      = r_overflow;
    assign fill          = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_i2s_capture_rpi_out.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_capture_rpi_out
//  Description : Self-checking bench; drives I2S frames and Pi reads against a
//                frame-level queue model of capture, FIFO and readout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_capture_rpi_out;

    localparam int W = 16;
    localparam int D = 4;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       i2s_bclk   = 1'b1;
    logic       i2s_lrclk  = 1'b1;
    logic       i2s_sdata  = 1'b0;
    logic       rpi_clk    = 1'b0;
    logic       rpi_enable = 1'b0;
    logic       rpi_serial;
    logic       rpi_interrupt;
    logic       overflow;
    logic [2:0] fill;

    int n_tests = 0;
    int n_fail  = 0;

    // frame-level model
    logic [2*W-1:0] m_q[$];
    bit             m_lv  = 0;
    logic [W-1:0]   m_left = '0;
    bit             m_ovf = 0;

    i2s_capture_rpi_out #(.WIDTH(W), .FIFO_DEPTH(D)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i2s_bclk      (i2s_bclk),
        .i2s_lrclk     (i2s_lrclk),
        .i2s_sdata     (i2s_sdata),
        .rpi_clk       (rpi_clk),
        .rpi_enable    (rpi_enable),
        .rpi_serial    (rpi_serial),
        .rpi_interrupt (rpi_interrupt),
        .overflow      (overflow),
        .fill          (fill)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".fill"}, 64'(fill), 64'(m_q.size()));
        check_eq({tag, ".irq"},  64'(rpi_interrupt), 64'(m_q.size() != 0));
        check_eq({tag, ".ovf"},  64'(overflow), 64'(m_ovf));
    endtask

    task automatic model_push(input logic [2*W-1:0] frame);
        if (m_q.size() < D) m_q.push_back(frame);
        else                m_ovf = 1;
    endtask

    // bclk = clk/16; data changes on the falling edge, ADC samples on the rising
    task automatic bit_cycle(input logic lr, input logic d, input bit en_at_rise);
        i2s_bclk  = 1'b0;
        i2s_lrclk = lr;
        i2s_sdata = d;
        repeat (8) @(negedge clk);
        i2s_bclk = 1'b1;
        if (en_at_rise) rpi_enable = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // One lrclk half: delay slot, nbits data bits MSB first, then extra junk bits.
    task automatic send_slot(input logic lr, input logic [W-1:0] word, input int nbits,
                             input int extra, input bit en_last);
        bit_cycle(lr, 1'($urandom_range(0, 1)), 0);
        for (int i = 0; i < nbits; i++) bit_cycle(lr, word[W-1-i], en_last && (i == W-1));
        for (int i = 0; i < extra; i++) bit_cycle(lr, 1'($urandom_range(0, 1)), 0);
        if (!lr) begin
            if (nbits >= W) begin m_left = word; m_lv = 1; end
            else            m_lv = 0;
        end else if (nbits >= W && m_lv) begin
            model_push({m_left, word});
            m_lv = 0;
        end
    endtask

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r);
        send_slot(1'b0, l, W, 15, 0);
        send_slot(1'b1, r, W, 15, 0);
    endtask

    task automatic pi_read(input int nbits, input bit pre_enabled, output logic [63:0] bits);
        if (!pre_enabled) rpi_enable = 1'b1;
        repeat (6) @(negedge clk);
        bits = '0;
        for (int i = 0; i < nbits; i++) begin
            bits = {bits[62:0], rpi_serial};
            rpi_clk = 1'b1;
            repeat (6) @(negedge clk);
            rpi_clk = 1'b0;
            repeat (6) @(negedge clk);
        end
        rpi_enable = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    function automatic logic [63:0] expect_bits(input logic [2*W-1:0] frame, input int nbits);
        logic [63:0] e;
        e = {32'b0, frame};
        if (nbits <= 2*W) e = e >> (2*W - nbits);
        else              e = e << (nbits - 2*W);
        return e;
    endfunction

    task automatic read_check(input string tag, input int nbits);
        logic [2*W-1:0] exp;
        logic [63:0]    bits;
        exp   = (m_q.size() != 0) ? m_q.pop_front() : '0;
        m_ovf = 0;
        pi_read(nbits, 0, bits);
        check_eq({tag, ".data"}, bits, expect_bits(exp, nbits));
        check_state(tag);
    endtask

    initial begin
        logic [63:0]    bits;
        logic [2*W-1:0] exp;
        logic [W-1:0]   lw, rw;
        int             ln, rn;

        // reset held while inputs toggle
        rst_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            i2s_bclk   = 1'($urandom_range(0, 1));
            i2s_lrclk  = 1'($urandom_range(0, 1));
            i2s_sdata  = 1'($urandom_range(0, 1));
            rpi_clk    = 1'($urandom_range(0, 1));
            rpi_enable = 1'($urandom_range(0, 1));
            repeat (8) @(negedge clk);
            check_eq("reset_outputs", {58'b0, rpi_serial, rpi_interrupt, overflow, fill}, 64'd0);
        end
        i2s_bclk = 1'b1; i2s_lrclk = 1'b1; i2s_sdata = 1'b0; rpi_clk = 1'b0; rpi_enable = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_state("post_reset");
        check_eq("post_reset.serial", 64'(rpi_serial), 64'd0);

        // single frame
        send_slot(1'b0, 16'hA5C3, W, 15, 0);
        check_state("left_only");
        send_slot(1'b1, 16'h1234, W, 15, 0);
        check_state("single_push");
        check_eq("single_fill", 64'(fill), 64'd1);
        read_check("single_read", 32);

        // overflow: five frames, no reads
        for (int k = 0; k < 5; k++) send_frame(16'(2*k+1), 16'(2*k+2));
        check_state("overflow");
        check_eq("overflow_flag", 64'(overflow), 64'd1);
        for (int k = 0; k < 4; k++) read_check("overflow_read", 32);

        // empty read
        read_check("empty_read", 32);

        // overclocked read and mid-frame abort
        send_frame(16'hBEEF, 16'hCAFE);
        read_check("over_read", 34);
        send_frame(16'h0F0F, 16'h7001);
        read_check("abort_read", 10);

        // short slots: an early left slot must cancel the held left word
        send_slot(1'b0, 16'h1111, W, 15, 0);
        send_slot(1'b1, 16'h2222, 5, 0, 0);
        send_slot(1'b0, 16'h3333, 8, 0, 0);
        send_slot(1'b1, 16'h4444, W, 15, 0);
        check_state("short_slot");

        // reset pulse inside a right slot
        send_slot(1'b0, 16'h5555, W, 15, 0);
        bit_cycle(1'b1, 1'b0, 0);
        for (int i = 0; i < W + 15; i++) begin
            if (i == 5) rst_n = 1'b0;
            if (i == 8) begin
                rst_n = 1'b1;
                m_q.delete(); m_lv = 0; m_ovf = 0;
            end
            bit_cycle(1'b1, 1'($urandom_range(0, 1)), 0);
        end
        check_state("reset_mid_slot");
        send_frame(16'h6789, 16'hABCD);
        check_state("after_reset_frame");
        read_check("after_reset_read", 32);

        // full FIFO, read start coinciding with a push
        for (int k = 0; k < 4; k++) send_frame(16'(16'h0100 + k), 16'(16'h0200 + k));
        send_slot(1'b0, 16'hD00D, W, 15, 0);
        exp   = m_q.pop_front();
        m_ovf = 0;
        send_slot(1'b1, 16'hF00D, W, 15, 1);
        check_state("simul");
        pi_read(32, 1, bits);
        check_eq("simul.data", bits, expect_bits(exp, 32));
        for (int k = 0; k < 4; k++) read_check("simul_drain", 32);

        // randomized frames and reads
        for (int it = 0; it < 25; it++) begin
            lw = 16'($urandom);
            rw = 16'($urandom);
            ln = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, W-1)) : W;
            rn = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, W-1)) : W;
            send_slot(1'b0, lw, ln, (ln == W) ? int'($urandom_range(0, 3)) : 0, 0);
            send_slot(1'b1, rw, rn, (rn == W) ? int'($urandom_range(0, 3)) : 0, 0);
            check_state("rand_frame");
            if ($urandom_range(0, 2) == 0) read_check("rand_read", int'($urandom_range(20, 34)));
        end
        while (m_q.size() != 0) read_check("rand_drain", 32);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
